// File: rtl/op_encode.sv
// Purpose: 6502 instruction emitter; turns {mnemonic, mode, operand} into opcode + operand bytes written at a tracked pc.
// Latency: first byte valid 2 cycles after accept; then 1 byte/cycle, 1 idle cycle before the next accept.
// Backpressure: each byte holds stable until out_ready; in_ready is low whenever not IDLE or org_valid is high.
module op_encode #(
    parameter logic [15:0] ORG_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        org_valid,
    input  logic [15:0] org_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_mnem,
    input  logic [3:0]  in_mode,
    input  logic [15:0] in_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_addr,
    output logic [7:0]  out_data,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] pc,
    output logic        busy
);
    localparam logic [3:0] M_IMP = 4'd0,  M_ACC = 4'd1,  M_IMM = 4'd2,  M_ZPG = 4'd3;
    localparam logic [3:0] M_ZPX = 4'd4,  M_ZPY = 4'd5,  M_ABS = 4'd6,  M_ABX = 4'd7;
    localparam logic [3:0] M_ABY = 4'd8,  M_IND = 4'd9,  M_XIN = 4'd10, M_INY = 4'd11;
    localparam logic [3:0] M_REL = 4'd12;

    typedef enum logic [2:0] {S_IDLE, S_LOOK, S_OPC, S_LO, S_HI} state_t;

    state_t      state_q, state_d;
    logic [5:0]  mnem_q, mnem_d;
    logic [3:0]  mode_q, mode_d;
    logic [15:0] operand_q, operand_d;
    logic [7:0]  opc_q, opc_d;
    logic [7:0]  b1_q, b1_d;
    logic [15:0] pc_q, pc_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic [8:0]  lk;
    logic [15:0] off;
    logic [1:0]  len;

    // Returns {legal, opcode}. Regular groups use the aaa-bbb-cc opcode layout; the rest are enumerated.
    function automatic logic [8:0] lookup(input logic [5:0] m, input logic [3:0] md);
        logic       ok;
        logic [7:0] op;
        logic [2:0] aaa;
        logic [2:0] bbb;
        logic       ldx_stx;
        ok = 1'b0; op = 8'h00; aaa = 3'd0; bbb = 3'd0;
        ldx_stx = (m == 6'd30) || (m == 6'd48);
        case (m)
            // ORA AND EOR ADC STA LDA CMP SBC
            6'd0, 6'd1, 6'd17, 6'd23, 6'd29, 6'd34, 6'd43, 6'd47: begin
                case (m)
                    6'd34:   aaa = 3'd0;
                    6'd1:    aaa = 3'd1;
                    6'd23:   aaa = 3'd2;
                    6'd0:    aaa = 3'd3;
                    6'd47:   aaa = 3'd4;
                    6'd29:   aaa = 3'd5;
                    6'd17:   aaa = 3'd6;
                    default: aaa = 3'd7;
                endcase
                ok = 1'b1;
                case (md)
                    M_XIN:   bbb = 3'd0;
                    M_ZPG:   bbb = 3'd1;
                    M_IMM:   begin bbb = 3'd2; ok = (m != 6'd47); end
                    M_ABS:   bbb = 3'd3;
                    M_INY:   bbb = 3'd4;
                    M_ZPX:   bbb = 3'd5;
                    M_ABY:   bbb = 3'd6;
                    M_ABX:   bbb = 3'd7;
                    default: ok = 1'b0;
                endcase
                op = {aaa, bbb, 2'b01};
            end
            // ASL ROL LSR ROR STX LDX DEC INC
            6'd2, 6'd39, 6'd32, 6'd40, 6'd48, 6'd30, 6'd20, 6'd24: begin
                case (m)
                    6'd2:    aaa = 3'd0;
                    6'd39:   aaa = 3'd1;
                    6'd32:   aaa = 3'd2;
                    6'd40:   aaa = 3'd3;
                    6'd48:   aaa = 3'd4;
                    6'd30:   aaa = 3'd5;
                    6'd20:   aaa = 3'd6;
                    default: aaa = 3'd7;
                endcase
                case (md)
                    M_IMM:   begin bbb = 3'd0; ok = (m == 6'd30); end
                    M_ZPG:   begin bbb = 3'd1; ok = 1'b1; end
                    M_ACC:   begin bbb = 3'd2; ok = (aaa < 3'd4); end
                    M_ABS:   begin bbb = 3'd3; ok = 1'b1; end
                    M_ZPX:   begin bbb = 3'd5; ok = !ldx_stx; end
                    M_ZPY:   begin bbb = 3'd5; ok = ldx_stx; end
                    M_ABX:   begin bbb = 3'd7; ok = !ldx_stx; end
                    M_ABY:   begin bbb = 3'd7; ok = (m == 6'd30); end
                    default: ok = 1'b0;
                endcase
                op = {aaa, bbb, 2'b10};
            end
            6'd6: begin ok = 1'b1; case (md) M_ZPG: op = 8'h24; M_ABS: op = 8'h2C; default: ok = 1'b0; endcase end
            6'd49: begin ok = 1'b1; case (md) M_ZPG: op = 8'h84; M_ZPX: op = 8'h94; M_ABS: op = 8'h8C; default: ok = 1'b0; endcase end
            6'd31: begin
                ok = 1'b1;
                case (md)
                    M_IMM: op = 8'hA0; M_ZPG: op = 8'hA4; M_ZPX: op = 8'hB4; M_ABS: op = 8'hAC; M_ABX: op = 8'hBC;
                    default: ok = 1'b0;
                endcase
            end
            6'd19: begin ok = 1'b1; case (md) M_IMM: op = 8'hC0; M_ZPG: op = 8'hC4; M_ABS: op = 8'hCC; default: ok = 1'b0; endcase end
            6'd18: begin ok = 1'b1; case (md) M_IMM: op = 8'hE0; M_ZPG: op = 8'hE4; M_ABS: op = 8'hEC; default: ok = 1'b0; endcase end
            6'd27: begin ok = 1'b1; case (md) M_ABS: op = 8'h4C; M_IND: op = 8'h6C; default: ok = 1'b0; endcase end
            6'd28: begin ok = (md == M_ABS); op = 8'h20; end
            // Branches: BCC BCS BEQ BMI BNE BPL BVC BVS
            6'd3, 6'd4, 6'd5, 6'd7, 6'd8, 6'd9, 6'd11, 6'd12: begin
                ok = (md == M_REL);
                case (m)
                    6'd3: op = 8'h90; 6'd4: op = 8'hB0; 6'd5: op = 8'hF0; 6'd7: op = 8'h30;
                    6'd8: op = 8'hD0; 6'd9: op = 8'h10; 6'd11: op = 8'h50; default: op = 8'h70;
                endcase
            end
            // Implied-only mnemonics
            6'd10, 6'd13, 6'd14, 6'd15, 6'd16, 6'd21, 6'd22, 6'd25, 6'd26, 6'd33, 6'd35, 6'd36, 6'd37,
            6'd38, 6'd41, 6'd42, 6'd44, 6'd45, 6'd46, 6'd50, 6'd51, 6'd52, 6'd53, 6'd54, 6'd55: begin
                ok = (md == M_IMP);
                case (m)
                    6'd10: op = 8'h00; 6'd13: op = 8'h18; 6'd14: op = 8'hD8; 6'd15: op = 8'h58;
                    6'd16: op = 8'hB8; 6'd21: op = 8'hCA; 6'd22: op = 8'h88; 6'd25: op = 8'hE8;
                    6'd26: op = 8'hC8; 6'd33: op = 8'hEA; 6'd35: op = 8'h48; 6'd36: op = 8'h08;
                    6'd37: op = 8'h68; 6'd38: op = 8'h28; 6'd41: op = 8'h40; 6'd42: op = 8'h60;
                    6'd44: op = 8'h38; 6'd45: op = 8'hF8; 6'd46: op = 8'h78; 6'd50: op = 8'hAA;
                    6'd51: op = 8'hA8; 6'd52: op = 8'hBA; 6'd53: op = 8'h8A; 6'd54: op = 8'h9A;
                    default: op = 8'h98;
                endcase
            end
            default: ok = 1'b0;
        endcase
        return {ok, op};
    endfunction

    // Table lookup, branch offset and instruction length from the captured request.
    always_comb begin
        lk  = lookup(mnem_q, mode_q);
        off = operand_q - (pc_q + 16'd2);
        case (mode_q)
            M_IMP, M_ACC:               len = 2'd1;
            M_ABS, M_ABX, M_ABY, M_IND: len = 2'd3;
            default:                    len = 2'd2;
        endcase
    end

    // Next-state, handshakes and byte presentation.
    always_comb begin
        state_d    = state_q;
        mnem_d     = mnem_q;
        mode_d     = mode_q;
        operand_d  = operand_q;
        opc_d      = opc_q;
        b1_d       = b1_q;
        pc_d       = pc_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_addr   = 16'h0000;
        out_data   = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (org_valid) begin
                    pc_d = org_addr;
                end else if (!rst) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        mnem_d    = in_mnem;
                        mode_d    = in_mode;
                        operand_d = in_operand;
                        state_d   = S_LOOK;
                    end
                end
            end
            S_LOOK: begin
                if (!lk[8]) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    state_d    = S_IDLE;
                end else if (mode_q == M_REL && !(off[15:7] == 9'h000 || off[15:7] == 9'h1FF)) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = S_IDLE;
                end else begin
                    opc_d   = lk[7:0];
                    b1_d    = (mode_q == M_REL) ? off[7:0] : operand_q[7:0];
                    state_d = S_OPC;
                end
            end
            S_OPC, S_LO, S_HI: begin
                out_valid = 1'b1;
                out_addr  = pc_q;
                out_data  = (state_q == S_OPC) ? opc_q :
                            (state_q == S_LO)  ? b1_q  : operand_q[15:8];
                if (out_ready) begin
                    pc_d = pc_q + 16'd1;
                    if (state_q == S_OPC)
                        state_d = (len == 2'd1) ? S_IDLE : S_LO;
                    else if (state_q == S_LO)
                        state_d = (len == 2'd2) ? S_IDLE : S_HI;
                    else
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any instruction in flight and restores the origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mnem_q     <= 6'd0;
            mode_q     <= 4'd0;
            operand_q  <= 16'h0000;
            opc_q      <= 8'h00;
            b1_q       <= 8'h00;
            pc_q       <= ORG_RESET;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            mnem_q     <= mnem_d;
            mode_q     <= mode_d;
            operand_q  <= operand_d;
            opc_q      <= opc_d;
            b1_q       <= b1_d;
            pc_q       <= pc_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;
    assign pc       = pc_q;
    assign busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_op_encode.sv
module tb_op_encode;
    localparam logic [3:0] IMP = 4'd0, ACC = 4'd1, IMM = 4'd2, ZPG = 4'd3, ABS = 4'd6;
    localparam logic [3:0] ABX = 4'd7, IND = 4'd9, REL = 4'd12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        org_valid = 1'b0;
    logic [15:0] org_addr = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_mnem = 6'd0;
    logic [3:0]  in_mode = 4'd0;
    logic [15:0] in_operand = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_addr;
    logic [7:0]  out_data;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] pc;
    logic        busy;

    always #5 clk = ~clk;

    op_encode #(.ORG_RESET(16'h0000)) dut (
        .clk(clk), .rst(rst), .org_valid(org_valid), .org_addr(org_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem), .in_mode(in_mode),
        .in_operand(in_operand), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .err(err), .err_code(err_code),
        .pc(pc), .busy(busy)
    );

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [15:0] a, input logic [7:0] d);
        exp_t x;
        x.is_err = 1'b0; x.code = 2'd0; x.addr = a; x.data = d;
        q.push_back(x);
    endtask

    task automatic push_err(input logic [1:0] c);
        exp_t x;
        x.is_err = 1'b1; x.code = c; x.addr = 16'h0000; x.data = 8'h00;
        q.push_back(x);
    endtask

    // Monitor: every byte handshake or err pulse consumes one expected event in order.
    always @(negedge clk) begin
        if (!rst) begin
            chk("err_excl_valid", {31'b0, err & out_valid}, 32'd0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte: got %h:%h, expected none", out_addr, out_data);
                end else begin
                    e = q.pop_front();
                    chk("byte_kind", {31'b0, e.is_err}, 32'd0);
                    chk("byte_addr", {16'b0, out_addr}, {16'b0, e.addr});
                    chk("byte_data", {24'b0, out_data}, {24'b0, e.data});
                end
            end
            if (err) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err: got code %0d, expected none", err_code);
                end else begin
                    e = q.pop_front();
                    chk("err_kind", {31'b0, e.is_err}, 32'd1);
                    chk("err_code", {30'b0, err_code}, {30'b0, e.code});
                end
            end
        end
    end

    task automatic send(input logic [5:0] m, input logic [3:0] md, input logic [15:0] op);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_mnem = m; in_mode = md; in_operand = op;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (in_ready === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=%b, expected 1", in_ready);
        end else begin
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic set_org(input logic [15:0] a);
        @(negedge clk);
        org_valid = 1'b1; org_addr = a;
        @(posedge clk);
        #1 org_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (!busy && q.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got busy=%b pending=%0d, expected idle", name, busy, q.size());
        end
    endtask

    task automatic rdy_back(input string name);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            cnt++;
            if (in_ready) break;
        end
        chk(name, cnt, 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        bit found;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_addr", {16'b0, out_addr}, 32'h0);
        chk("rst_out_data", {24'b0, out_data}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_err_code", {30'b0, err_code}, 32'd0);
        chk("rst_pc", {16'b0, pc}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

        // LDA #$42 at $0600 with first-byte latency
        set_org(16'h0600);
        push_byte(16'h0600, 8'hA9); push_byte(16'h0601, 8'h42);
        send(6'd29, IMM, 16'h0042);
        @(negedge clk);
        chk("lat_look", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_first", {31'b0, out_valid}, 32'd1);
        wait_done("lda");
        chk("pc_lda", {16'b0, pc}, 32'h0602);
        chk("err_lda", {31'b0, err}, 32'd0);

        // JMP ($1234) then STA $C000,X back to back
        set_org(16'h0600);
        push_byte(16'h0600, 8'h6C); push_byte(16'h0601, 8'h34); push_byte(16'h0602, 8'h12);
        push_byte(16'h0603, 8'h9D); push_byte(16'h0604, 8'h00); push_byte(16'h0605, 8'hC0);
        send(6'd27, IND, 16'h1234);
        send(6'd47, ABX, 16'hC000);
        wait_done("jmp_sta");
        chk("pc_jmp_sta", {16'b0, pc}, 32'h0606);

        // Branch in range, then out of range
        set_org(16'h0600);
        push_byte(16'h0600, 8'hD0); push_byte(16'h0601, 8'hEE);
        send(6'd8, REL, 16'h05F0);
        wait_done("bne_ok");
        chk("pc_bne_ok", {16'b0, pc}, 32'h0602);
        set_org(16'h0600);
        push_err(2'd2);
        send(6'd8, REL, 16'h0700);
        wait_done("bne_far");
        chk("pc_bne_far", {16'b0, pc}, 32'h0600);
        chk("err_code_hold2", {30'b0, err_code}, 32'd2);

        // Illegal pairs / reserved mnemonic
        push_err(2'd1);
        send(6'd29, ACC, 16'h0000);
        rdy_back("rdy_lda_acc");
        wait_done("lda_acc");
        push_err(2'd1);
        send(6'd27, ZPG, 16'h0010);
        rdy_back("rdy_jmp_zpg");
        wait_done("jmp_zpg");
        push_err(2'd1);
        send(6'd60, IMM, 16'h0001);
        rdy_back("rdy_mnem60");
        wait_done("mnem60");
        push_err(2'd1);
        send(6'd47, IMM, 16'h0001);
        wait_done("sta_imm");
        chk("pc_after_errs", {16'b0, pc}, 32'h0600);
        chk("err_code_hold1", {30'b0, err_code}, 32'd1);
        push_byte(16'h0600, 8'h0A);
        send(6'd2, ACC, 16'h0000);
        wait_done("asl_acc");
        chk("pc_asl", {16'b0, pc}, 32'h0601);

        // JSR straddling $FFFF with backpressure on the first byte
        set_org(16'hFFFE);
        out_ready = 1'b0;
        push_byte(16'hFFFE, 8'h20); push_byte(16'hFFFF, 8'hCD); push_byte(16'h0000, 8'hAB);
        send(6'd28, ABS, 16'hABCD);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        chk("jsr_valid_seen", {31'b0, found}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_data", {24'b0, out_data}, 32'h20);
            chk("hold_addr", {16'b0, out_addr}, 32'hFFFE);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done("jsr");
        chk("pc_jsr_wrap", {16'b0, pc}, 32'h0001);

        // Reset after the first byte of a 3-byte instruction
        set_org(16'h0300);
        push_byte(16'h0300, 8'h8D);
        send(6'd47, ABS, 16'h1234);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        chk("sta_first_seen", {31'b0, found}, 32'd1);
        @(posedge clk); #1 rst = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_pc", {16'b0, pc}, 32'h0000);
        chk("abort_err", {31'b0, err}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_pending", q.size(), 32'd0);

        // org_valid and in_valid together: org wins, instruction taken next cycle
        @(negedge clk);
        org_valid = 1'b1; org_addr = 16'h0800;
        in_valid = 1'b1; in_mnem = 6'd33; in_mode = IMP; in_operand = 16'h0000;
        #1;
        chk("org_blocks_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1 org_valid = 1'b0;
        push_byte(16'h0800, 8'hEA);
        @(negedge clk); #1;
        chk("ready_after_org", {31'b0, in_ready}, 32'd1);
        chk("pc_after_org", {16'b0, pc}, 32'h0800);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_done("nop");
        chk("pc_nop", {16'b0, pc}, 32'h0801);

        repeat (3) @(negedge clk);
        chk("final_pending", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/op_encode.md
Name: op_encode

Overview:
- Instruction emitter; the inverse of the opcode decoder.
- Accepts one symbolic 6502 instruction per handshake: mnemonic ID, addressing mode and operand.
- Produces the legal NMOS opcode byte and 0-2 operand bytes as an addressed byte-write stream.
- Used by the boot/program loader and the self-test bench to place code into RAM at a tracked program counter.

Parameters:
- ORG_RESET, 16'h0000, program counter value after reset.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  synchronous reset, active-high.
- org_valid  in  1  load a new program counter (honoured only in IDLE).
- org_addr  in  16  new program counter value.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  instruction request accepted when in_valid & in_ready.
- in_mnem  in  6  mnemonic ID: the 56 NMOS mnemonics in alphabetical order, ADC=0 … TYA=55 (e.g. BNE=8, JMP=27, LDA=29, STA=47). 56-63 are invalid.
- in_mode  in  4  addressing mode: IMP=0, ACC=1, IMM=2, ZPG=3, ZPX=4, ZPY=5, ABS=6, ABX=7, ABY=8, IND=9, XIN=10, INY=11, REL=12. 13-15 are invalid.
- in_operand  in  16  operand. 8-bit modes use [7:0]. ABS-class modes use the full word. REL carries the absolute branch target.
- out_valid  out  1  byte valid.
- out_ready  in  1  byte accepted when out_valid & out_ready.
- out_addr  out  16  write address of the current byte.
- out_data  out  8  current byte.
- err  out  1  one-cycle pulse: request rejected.
- err_code  out  2  1 = illegal mnemonic/mode pair, 2 = branch out of range. Holds until the next err.
- pc  out  16  next write address.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_addr=0, out_data=0, err=0, err_code=0, pc=ORG_RESET, busy=0. The FSM goes to IDLE; in_ready rises the cycle after rst deasserts.
- FSM states: IDLE, LOOK, OPC, LO, HI.
- IDLE:
  - in_ready=1 except in a cycle where org_valid=1.
  - org_valid has priority: pc<=org_addr, in_ready=0 that cycle, and any in_valid is not accepted.
  - On accept, mnem/mode/operand are registered and the FSM goes to LOOK.
- LOOK (1 cycle):
  - Table lookup gives opcode and length (1-3).
  - For REL: offset = operand - (pc + 2), computed mod 2^16, signed. It is in range if -128..+127; the low byte is emitted.
  - If the pair is illegal or the mnemonic/mode is reserved: err=1, err_code=1, go to IDLE.
  - If the branch is out of range: err=1, err_code=2, go to IDLE.
  - Otherwise go to OPC.
  - On either error no bytes are emitted and pc is unchanged.
- Legality rules:
  - Only official NMOS pairs are legal.
  - ACC is legal only for ASL/LSR/ROL/ROR.
  - Implied-only mnemonics accept only IMP. BRK with IMP emits the single byte 00.
  - JMP accepts only ABS (4C) and IND (6C). JSR accepts only ABS (20).
  - Branches accept only REL.
  - ZPY is legal only for LDX/STX. ABY is legal for LDX.
- OPC / LO / HI states:
  - out_valid=1, out_addr=pc, out_data = opcode / operand[7:0] (or branch offset) / operand[15:8] respectively.
  - Each byte holds stable until out_ready.
  - On handshake: pc<=pc+1, wrapping FFFF->0000.
  - Advance to the next byte by length; after the last byte go to IDLE.
  - out_valid never drops before its handshake.
- Throughput and latency:
  - Accept to first out_valid is 2 cycles.
  - Best case is 1 byte/cycle, then 1 idle cycle before the next accept.
- Multi-byte instructions may straddle FFFF->0000: address wraps, data is unaffected.
- org_valid outside IDLE is ignored (not queued).
- rst mid-emission aborts the instruction: partial bytes already written stay written, pc returns to ORG_RESET, no err.
- err and out_valid are never high in the same cycle.

Test Plan:
- rst; org $0600; LDA(29)/IMM/$0042 -> writes 0600:A9, 0601:42; pc=$0602; err=0.
- From $0600, JMP(27)/IND/$1234 then STA(47)/ABX/$C000 -> writes 6C 34 12 at 0600-0602, then 9D 00 C0 at 0603-0605.
- pc=$0600, BNE(8)/REL target $05F0 -> D0 EE. Same with target $0700 -> err pulse, err_code=2, no writes, pc stays $0600.
- LDA/ACC, JMP/ZPG, mnem=60 -> err_code=1 each, in_ready back within 2 cycles. Then ASL(2)/ACC -> single byte 0A.
- org $FFFE; JSR(28)/ABS/$ABCD with out_ready held low 5 cycles -> byte 20 held stable at FFFE; bytes CD,AB land at FFFF,0000; pc=$0001.
- Assert rst after the first byte of a 3-byte instruction -> out_valid=0 next cycle, pc=ORG_RESET. org_valid and in_valid together in IDLE -> org taken, instruction accepted the following cycle at the new pc.
